// File: rtl/display_scan_controller_pkg.sv
// Shared widths and scan FSM encoding for the multiplexed 8-digit display scanner.
// Pure declarations; no timing or flow-control behaviour of its own.
package display_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 3;
    localparam int PWM_W      = 3;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        GUARD  = 2'd1,
        ACTIVE = 2'd2
    } scan_state_t;

    // Active-low anode pattern with only digit d driven.
    function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [DIGIT_W-1:0] d);
        logic [NUM_DIGITS-1:0] v;
        v    = '1;
        v[d] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Control/status bundle between a display host and the scan controller.
// Level signals only; no handshake, the controller never stalls its host.
interface display_scan_if;
    import display_pkg::*;

    logic                  enable;
    logic [NUM_DIGITS-1:0] digit_mask;
    logic [PWM_W-1:0]      brightness;
    logic [DIGIT_W-1:0]    displayDigit;
    logic [NUM_DIGITS-1:0] anode;
    logic                  frame_tick;

    modport master (
        output enable, digit_mask, brightness,
        input  displayDigit, anode, frame_tick
    );

    modport slave (
        input  enable, digit_mask, brightness,
        output displayDigit, anode, frame_tick
    );

endinterface

// File: rtl/display_scan_controller_timer.sv
// Per-slot cycle counter with terminal-count and end-of-guard flags.
// Flags are combinational from the counter register; count_en low holds it at zero.
module scan_timer #(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en,
    output logic slot_done,
    output logic guard_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || !count_en) begin
            cnt <= '0;
        end else if (cnt == SLOT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign slot_done  = (cnt == SLOT_LAST);
    assign guard_done = (cnt == GUARD_LAST);

endmodule

// File: rtl/display_scan_controller.sv
// 8-digit multiplexed display scanner: guard-blanked slots, PWM brightness, frame pulse.
// All outputs registered, one cycle after inputs; no backpressure.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         reset,
    display_scan_if.slave dsp
);

    scan_state_t           state, state_nxt;
    logic [DIGIT_W-1:0]    digit, digit_nxt;
    logic [PWM_W-1:0]      pwm, pwm_nxt;
    logic [NUM_DIGITS-1:0] anode_q, anode_nxt;
    logic                  tick_q, tick_nxt;
    logic                  count_en;
    logic                  slot_done;
    logic                  guard_done;

    assign count_en = dsp.enable && (state != OFF);

    scan_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_en   (count_en),
        .slot_done  (slot_done),
        .guard_done (guard_done)
    );

    always_comb begin
        state_nxt = state;
        digit_nxt = digit;
        pwm_nxt   = pwm;
        tick_nxt  = 1'b0;
        anode_nxt = '1;

        if (!dsp.enable) begin
            state_nxt = OFF;
            digit_nxt = '0;
            pwm_nxt   = '0;
        end else begin
            unique case (state)
                OFF: begin
                    state_nxt = GUARD;
                    digit_nxt = '0;
                    pwm_nxt   = '0;
                end
                GUARD: begin
                    if (guard_done) begin
                        state_nxt = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (slot_done) begin
                        state_nxt = GUARD;
                        digit_nxt = digit + DIGIT_W'(1);
                        pwm_nxt   = '0;
                        tick_nxt  = (digit == DIGIT_W'(NUM_DIGITS - 1));
                    end else begin
                        pwm_nxt = pwm + PWM_W'(1);
                    end
                end
                default: begin
                    state_nxt = OFF;
                    digit_nxt = '0;
                    pwm_nxt   = '0;
                end
            endcase
        end

        // Anode is decoded from the next state so it lines up with displayDigit
        // and goes dark in the same cycle the FSM leaves ACTIVE.
        if ((state_nxt == ACTIVE) && (pwm_nxt <= dsp.brightness)
                && !dsp.digit_mask[digit_nxt]) begin
            anode_nxt = anode_sel(digit_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= OFF;
            digit   <= '0;
            pwm     <= '0;
            anode_q <= '1;
            tick_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            digit   <= digit_nxt;
            pwm     <= pwm_nxt;
            anode_q <= anode_nxt;
            tick_q  <= tick_nxt;
        end
    end

    assign dsp.displayDigit = digit;
    assign dsp.anode        = anode_q;
    assign dsp.frame_tick   = tick_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench: a time-since-enable model predicts every output cycle.
module tb_display_scan_controller;

    localparam int R = 8;
    localparam int G = 2;

    typedef struct {
        logic [2:0] digit;
        logic [7:0] anode;
        logic       tick;
        logic       guard;
        logic [7:0] mask;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb[$];
    bit   m_run;
    int   m_t;

    display_scan_if dsp_if();

    display_scan_controller #(
        .REFRESH_DIV  (R),
        .GUARD_CYCLES (G)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .dsp   (dsp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, got, want);
        end
    endtask

    // Drive one cycle of stimulus and push what the outputs must read after the edge.
    task automatic step(input bit r, input bit en, input logic [7:0] m, input logic [2:0] b);
        exp_t e;
        int   slot;
        int   pos;
        int   dig;
        @(negedge clk);
        #1;
        rst                = r;
        dsp_if.enable      = en;
        dsp_if.digit_mask  = m;
        dsp_if.brightness  = b;
        e.digit = 3'd0;
        e.anode = 8'hFF;
        e.tick  = 1'b0;
        e.guard = 1'b0;
        e.mask  = m;
        if (r || !en) begin
            m_run = 1'b0;
            m_t   = 0;
        end else begin
            if (!m_run) begin
                m_run = 1'b1;
                m_t   = 0;
            end else begin
                m_t++;
            end
            slot    = m_t / R;
            pos     = m_t % R;
            dig     = slot % 8;
            e.digit = 3'(dig);
            e.guard = (pos < G);
            e.tick  = (pos == 0) && (dig == 0) && (slot > 0);
            if (!e.guard && (((pos - G) % 8) <= int'(b)) && !m[dig]) begin
                e.anode[dig] = 1'b0;
            end
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("digit", 32'(dsp_if.displayDigit), 32'(e.digit));
            check_eq("anode", 32'(dsp_if.anode), 32'(e.anode));
            check_eq("tick", 32'(dsp_if.frame_tick), 32'(e.tick));
            check_eq("one_low", 32'($countones(~dsp_if.anode) <= 1), 32'd1);
            if (e.guard) begin
                check_eq("guard_dark", 32'(dsp_if.anode), 32'hFF);
            end
            if (e.mask[2] && (e.digit == 3'd2)) begin
                check_eq("mask2_dark", 32'(dsp_if.anode[2]), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        total = 0;
        bad   = 0;
        m_run = 1'b0;
        m_t   = 0;
        rst               = 1'b1;
        dsp_if.enable     = 1'b0;
        dsp_if.digit_mask = 8'h00;
        dsp_if.brightness = 3'd0;

        repeat (2) step(1'b1, 1'b0, 8'h00, 3'd0);
        repeat (2) step(1'b1, 1'b1, 8'h00, 3'd7);

        // Full brightness, two frames plus change.
        for (int i = 0; i < 140; i++) step(1'b0, 1'b1, 8'h00, 3'd7);
        // Minimum brightness taken mid-slot.
        for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 8'h00, 3'd0);
        // Digit 2 masked.
        for (int i = 0; i < 72; i++) step(1'b0, 1'b1, 8'h04, 3'd7);

        // Drop enable in digit 5, slot cycle 4.
        n = 0;
        while (!(m_run && ((m_t / R) % 8 == 5) && (m_t % R == 4)) && n < 200) begin
            step(1'b0, 1'b1, 8'h00, 3'd5);
            n++;
        end
        repeat (3) step(1'b0, 1'b0, 8'h00, 3'd5);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'h00, 3'd5);

        // Reset on the last active cycle of digit 7.
        n = 0;
        while (!(m_run && ((m_t / R) % 8 == 7) && (m_t % R == R - 1)) && n < 200) begin
            step(1'b0, 1'b1, 8'h00, 3'd7);
            n++;
        end
        step(1'b1, 1'b1, 8'h00, 3'd7);
        for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 8'h00, 3'd7);

        // Random mask/brightness with occasional enable dropouts.
        for (int i = 0; i < 300; i++) begin
            step(1'b0, ($urandom_range(0, 40) != 0), 8'($urandom_range(0, 255)),
                 3'($urandom_range(0, 7)));
        end

        @(negedge clk);
        #1;
        check_eq("drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (must be >= 4).
REQ-002 SHALL have parameter GUARD_CYCLES, default 1000, anode-off cycles at the start of each slot (must be < REFRESH_DIV - 1).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port enable, input, 1, scanning runs when 1; display is dark when 0.
REQ-006 SHALL have port digit_mask, input, 8, bit d=1 keeps digit d dark while it is still scanned.
REQ-007 SHALL have port brightness, input, 3, PWM duty level (0 = 1/8 … 7 = 8/8).
REQ-008 SHALL have port displayDigit, output, 3, index of the digit currently selected, fed to the decoder digit select.
REQ-009 SHALL have port anode, output, 8, active-low digit enables; bit d drives digit d.
REQ-010 SHALL have port frame_tick, output, 1, one-cycle pulse when the scan wraps from digit 7 to digit 0.

Function
REQ-011 SHALL implement FSM states OFF, GUARD and ACTIVE.
REQ-012 SHALL stay in OFF while enable=0, with slot counter=0, PWM counter=0, displayDigit=0, anode=8'hFF and frame_tick=0.
REQ-013 SHALL go OFF->GUARD on the first cycle enable=1, with the slot counter starting at 0 and displayDigit=0.
REQ-014 SHALL increment the slot counter every cycle in GUARD/ACTIVE, with range 0..REFRESH_DIV-1.
REQ-015 SHALL go GUARD->ACTIVE when the slot counter reaches GUARD_CYCLES-1 (the guard lasts exactly GUARD_CYCLES cycles).
REQ-016 SHALL, at slot counter REFRESH_DIV-1, clear the counter, advance displayDigit (7 wraps to 0), clear the PWM counter and enter GUARD.
REQ-017 SHALL, when displayDigit wraps 7->0, assert frame_tick in the same cycle that displayDigit registers 0, for exactly one cycle.
REQ-018 SHALL, in ACTIVE only, increment a 3-bit PWM counter every cycle, wrapping at 7.
REQ-019 SHALL, in ACTIVE, drive anode[displayDigit]=0 iff PWM counter <= brightness and digit_mask[displayDigit]=0; all other anode bits = 1.
REQ-020 SHALL hold anode = 8'hFF throughout GUARD and OFF, and never drive more than one anode bit low.
REQ-021 SHALL register all outputs, with anode reflecting state and counters with exactly one cycle of latency.
REQ-022 SHALL sample brightness and digit_mask every cycle, with changes taking effect within one cycle and no slot restart.
REQ-023 SHALL, on enable falling mid-slot, return to OFF next cycle, blank anode and reset displayDigit to 0, without producing a frame_tick.
REQ-024 SHALL, if reset and enable are both 1, give reset priority.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, enter OFF and set slot counter=0, PWM counter=0, displayDigit=0, anode=8'hFF and frame_tick=0.
REQ-026 SHALL, on reset mid-slot, abandon the slot; scanning restarts at digit 0 with a full guard after reset deasserts, if enable=1.

Structure
REQ-027 SHALL place NUM_DIGITS=8, DIGIT_W=3, PWM_W=3 and the FSM state enumeration in shared package display_pkg.
REQ-028 SHALL instantiate one sub-module, scan_timer (slot counter with terminal-count and guard-done flags), with FSM, PWM and anode logic in the top module.

Verification (REFRESH_DIV=8, GUARD_CYCLES=2)
REQ-029 SHALL verify reset then enable=1, mask=0, brightness=7 -> displayDigit steps 0..7 every 8 cycles, anode low for 6 of 8 cycles per slot, frame_tick once per 64 cycles.
REQ-030 SHALL verify brightness=0 -> active digit anode low exactly 1 cycle per 8 ACTIVE cycles (only when PWM counter=0).
REQ-031 SHALL verify digit_mask=8'b0000_0100 -> anode[2] never low while displayDigit still visits 2, with slot timing unchanged.
REQ-032 SHALL verify enable dropped in digit 5, cycle 4 -> next cycle anode=8'hFF and displayDigit=0, with no frame_tick.
REQ-033 SHALL verify reset asserted during ACTIVE of digit 7 -> no frame_tick and all outputs at reset values next cycle; after release, a 2-cycle guard precedes digit 0.
REQ-034 SHALL verify across all scenarios that at most one anode bit is low and anode=8'hFF in every GUARD cycle (assertion checks).
